// File: rtl/mask_index_encoder_if.sv
// Handshake bundle for mask_index_encoder: the load request, the index output stream,
// the completion pulse and the scan abort.
interface mask_index_encoder_if #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_index;
  logic             out_last;
  logic             done;
  logic             flush;

  // The master side issues masks and consumes indices; the encoder is the slave.
  modport master (
    output load_valid, load_mask, out_ready, flush,
    input  load_ready, out_valid, out_index, out_last, done
  );

  modport slave (
    input  load_valid, load_mask, out_ready, flush,
    output load_ready, out_valid, out_index, out_last, done
  );
endinterface

// File: rtl/mask_index_encoder.sv
// Sequential bitmask encoder: loads a WIDTH-bit mask and emits the index of each set
// bit, lowest first, one per output handshake.
module mask_index_encoder #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 5
) (
  input logic                 clock,
  input logic                 ctrl_reset_n,
  mask_index_encoder_if.slave bus
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] next_pending;
  logic             done_q;
  logic             next_done;
  logic [IDXW-1:0]  lowest_idx;
  logic             single_bit;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state   <= IDLE;
      pending <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      pending <= next_pending;
      done_q  <= next_done;
    end
  end

  // Lowest set bit of pending; an empty pending register encodes as index 0.
  always_comb begin
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        lowest_idx = IDXW'(i);
      end
    end
  end

  assign single_bit = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);

  always_comb begin
    next_state   = state;
    next_pending = pending;
    next_done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_valid) begin
          if (bus.load_mask != '0) begin
            next_pending = bus.load_mask;
            next_state   = SCAN;
          end else begin
            next_done = 1'b1;
          end
        end
      end
      SCAN: begin
        // Flush wins over a same-cycle transfer and suppresses the done pulse.
        if (bus.flush) begin
          next_pending = '0;
          next_state   = IDLE;
        end else if (bus.out_ready) begin
          next_pending = pending & (pending - WIDTH'(1));
          if (single_bit) begin
            next_state = IDLE;
            next_done  = 1'b1;
          end
        end
      end
      default: begin
        next_state   = IDLE;
        next_pending = '0;
      end
    endcase
  end

  assign bus.load_ready = (state == IDLE);
  assign bus.out_valid  = (state == SCAN);
  assign bus.out_index  = lowest_idx;
  assign bus.out_last   = single_bit;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_mask_index_encoder.sv
// Self-checking bench for mask_index_encoder: directed scenarios followed by random
// traffic, all compared against a queue-of-indices reference model.
module tb_mask_index_encoder;

  logic clock;
  logic ctrl_reset_n;

  mask_index_encoder_if #(.WIDTH(32), .IDXW(5)) bus ();

  mask_index_encoder #(.WIDTH(32), .IDXW(5)) dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .bus          (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: the indices still owed, in emission order, plus the done flag.
  int q[$];
  bit mdl_done = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic compareModel(input string tag);
    checkOutput({tag, ".out_valid"},  32'(bus.out_valid),  32'(q.size() > 0));
    checkOutput({tag, ".load_ready"}, 32'(bus.load_ready), 32'(q.size() == 0));
    checkOutput({tag, ".out_index"},  32'(bus.out_index),  (q.size() > 0) ? 32'(q[0]) : 32'd0);
    checkOutput({tag, ".out_last"},   32'(bus.out_last),   32'(q.size() == 1));
    checkOutput({tag, ".done"},       32'(bus.done),       32'(mdl_done));
  endtask

  // Drives one cycle of inputs from the falling edge, advances the model at the rising
  // edge and compares on the next falling edge.
  task automatic applyStimulus(input string tag, input bit lv, input logic [31:0] lm,
                               input bit ordy, input bit fl);
    bus.load_valid = lv;
    bus.load_mask  = lm;
    bus.out_ready  = ordy;
    bus.flush      = fl;
    @(posedge clock);
    mdl_done = 1'b0;
    if (q.size() > 0) begin
      if (fl) begin
        q.delete();
      end else if (ordy) begin
        void'(q.pop_front());
        if (q.size() == 0) mdl_done = 1'b1;
      end
    end else if (lv) begin
      if (lm == 32'd0) begin
        mdl_done = 1'b1;
      end else begin
        for (int i = 0; i < 32; i++) begin
          if (lm[i]) q.push_back(i);
        end
      end
    end
    @(negedge clock);
    compareModel(tag);
  endtask

  initial begin
    logic [31:0] rnd_mask;
    ctrl_reset_n   = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_mask  = '0;
    bus.out_ready  = 1'b0;
    bus.flush      = 1'b0;

    repeat (2) @(posedge clock);
    @(negedge clock);
    compareModel("reset");
    ctrl_reset_n = 1'b1;
    applyStimulus("idle", 1'b0, 32'd0, 1'b0, 1'b0);

    // Burst: indices 0, 4, 31 back to back, then done.
    applyStimulus("burst_load", 1'b1, 32'h8000_0011, 1'b1, 1'b0);
    checkOutput("burst_first_idx", 32'(bus.out_index), 32'd0);
    applyStimulus("burst_x1", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("burst_second_idx", 32'(bus.out_index), 32'd4);
    applyStimulus("burst_x2", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("burst_third_idx", 32'(bus.out_index), 32'd31);
    checkOutput("burst_third_last", 32'(bus.out_last), 32'd1);
    applyStimulus("burst_x3", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("burst_done", 32'(bus.done), 32'd1);
    checkOutput("burst_ready", 32'(bus.load_ready), 32'd1);

    // Backpressure holds index 1 for three cycles.
    applyStimulus("bp_load", 1'b1, 32'h0000_0006, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("bp_hold", 1'b0, 32'd0, 1'b0, 1'b0);
      checkOutput("bp_hold_idx", 32'(bus.out_index), 32'd1);
    end
    applyStimulus("bp_x1", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("bp_last_idx", 32'(bus.out_index), 32'd2);
    applyStimulus("bp_x2", 1'b0, 32'd0, 1'b1, 1'b0);

    // Empty mask gives a lone done pulse; a load during SCAN is ignored.
    applyStimulus("empty_load", 1'b1, 32'd0, 1'b1, 1'b0);
    checkOutput("empty_done", 32'(bus.done), 32'd1);
    applyStimulus("empty_after", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("empty_done_once", 32'(bus.done), 32'd0);
    applyStimulus("ign_load", 1'b1, 32'h0000_0A00, 1'b0, 1'b0);
    applyStimulus("ign_reload", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    checkOutput("ign_idx", 32'(bus.out_index), 32'd9);
    applyStimulus("ign_x1", 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus("ign_x2", 1'b0, 32'd0, 1'b1, 1'b0);

    // Flush after three transfers beats the index-3 transfer.
    applyStimulus("fl_load", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus("fl_x", 1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("fl_pre_idx", 32'(bus.out_index), 32'd3);
    applyStimulus("fl_flush", 1'b0, 32'd0, 1'b1, 1'b1);
    checkOutput("fl_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("fl_nodone", 32'(bus.done), 32'd0);
    applyStimulus("fl_idle", 1'b0, 32'd0, 1'b0, 1'b0);

    // Asynchronous reset between edges discards the scan.
    applyStimulus("ar_load", 1'b1, 32'h0000_F000, 1'b1, 1'b0);
    applyStimulus("ar_x12", 1'b0, 32'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    @(posedge clock);
    void'(q.pop_front());
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    q.delete();
    mdl_done = 1'b0;
    compareModel("ar_async");
    bus.out_ready = 1'b0;
    @(negedge clock);
    compareModel("ar_held");
    ctrl_reset_n = 1'b1;
    applyStimulus("ar_release", 1'b0, 32'd0, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       rnd_mask = 32'd0;
        1:       rnd_mask = 32'd1 << $urandom_range(0, 31);
        2:       rnd_mask = $urandom & $urandom & $urandom;
        default: rnd_mask = $urandom;
      endcase
      applyStimulus("rand", ($urandom_range(0, 2) == 0), rnd_mask,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 30) == 0));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
